// File: rtl/fpu_pkg.sv
// fpu_pkg: opcode encodings, binary32 field layout and constants shared by the fpu blocks.
package fpu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam int BIAS = 127;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;
endpackage

// File: rtl/fpu_round_pack.sv
// fpu_round_pack: RNE rounding of a normalised 24-bit mantissa plus guard/round/sticky,
// then packing to binary32 with overflow to infinity and flush-to-zero.
module fpu_round_pack
    import fpu_pkg::*;
(
    input  logic              sign_i,
    input  logic signed [9:0] exp_i,
    input  logic [26:0]       man_i,
    output logic [31:0]       res_o
);
    logic              up;
    logic [24:0]       m;
    logic signed [9:0] exp_r;
    logic [22:0]       frac;

    always_comb begin
        up = man_i[2] & (man_i[1] | man_i[0] | man_i[3]);
        m = {1'b0, man_i[26:3]} + {24'd0, up};
        exp_r = exp_i + $signed({9'd0, m[24]});
        frac = m[24] ? m[23:1] : m[22:0];
        res_o = (exp_r >= 10'sd255) ? {sign_i, POS_INF[30:0]} :
                (exp_r < 10'sd1)    ? {sign_i, 31'd0} :
                                      {sign_i, exp_r[7:0], frac};
    end
endmodule

// File: rtl/fpu.sv
// fpu: binary32 add/sub/mul/div with flush-to-zero inputs, RNE rounding and a single
// registered result stage; special operands bypass the shared round/pack stage.
module fpu
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic [31:0] result
);
    fp32_t fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic sb_e, eff_sub, sxor;
    logic [23:0] ma, mb;

    assign fa = a;
    assign fb = b;
    assign a_zero = fa.exp == 8'd0;
    assign b_zero = fb.exp == 8'd0;
    assign a_inf = fa.exp == 8'hFF && fa.frac == 23'd0;
    assign b_inf = fb.exp == 8'hFF && fb.frac == 23'd0;
    assign a_nan = fa.exp == 8'hFF && fa.frac != 23'd0;
    assign b_nan = fb.exp == 8'hFF && fb.frac != 23'd0;
    assign ma = a_zero ? 24'd0 : {1'b1, fa.frac};
    assign mb = b_zero ? 24'd0 : {1'b1, fb.frac};
    assign sb_e = fb.sign ^ (op == OP_SUB);
    assign eff_sub = fa.sign ^ sb_e;
    assign sxor = fa.sign ^ fb.sign;

    logic              swap, far, s_big;
    logic [7:0]        e_big, e_sml, d;
    logic [23:0]       m_big, m_sml;
    logic [49:0]       al_ext;
    logic [26:0]       al, add_man;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] add_exp;

    always_comb begin
        swap = {fb.exp, mb} > {fa.exp, ma};
        e_big = swap ? fb.exp : fa.exp;
        e_sml = swap ? fa.exp : fb.exp;
        m_big = swap ? mb : ma;
        m_sml = swap ? ma : mb;
        s_big = swap ? sb_e : fa.sign;
        d = e_big - e_sml;
        far = d >= 8'd26;
        al_ext = {m_sml, 26'd0} >> d;
        // Everything shifted past the round bit collapses into sticky.
        al = {al_ext[49:24], far ? |m_sml : |al_ext[23:0]};
        sum = eff_sub ? {1'b0, m_big, 3'b0} - {1'b0, al} : {1'b0, m_big, 3'b0} + {1'b0, al};
        lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);
        add_man = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0] << lz;
        add_exp = sum[27] ? {2'b0, e_big} + 10'd1 : {2'b0, e_big} - {5'd0, lz};
    end

    logic [47:0]       p, mul_n;
    logic [26:0]       mul_man;
    logic signed [9:0] mul_exp;

    always_comb begin
        p = {24'd0, ma} * {24'd0, mb};
        mul_n = p[47] ? p : {p[46:0], 1'b0};
        mul_man = {mul_n[47:22], |mul_n[21:0]};
        mul_exp = {2'b0, fa.exp} + {2'b0, fb.exp} - 10'(BIAS) + {9'd0, p[47]};
    end

    logic [26:0]       dq, div_man;
    logic [24:0]       rem;
    logic              rnz;
    logic signed [9:0] div_exp;

    always_comb begin
        dq = 27'd0;
        rem = {1'b0, ma};
        for (int i = 26; i >= 0; i--) begin
            dq[i] = rem >= {1'b0, mb};
            rem = dq[i] ? rem - {1'b0, mb} : rem;
            rem = {rem[23:0], 1'b0};
        end
        rnz = rem != 25'd0;
        div_man = dq[26] ? {dq[26:1], dq[0] | rnz} : {dq[25:0], rnz};
        div_exp = {2'b0, fa.exp} - {2'b0, fb.exp} + 10'(BIAS - 1) + {9'd0, dq[26]};
    end

    logic              rp_sign;
    logic signed [9:0] rp_exp;
    logic [26:0]       rp_man;
    logic [31:0]       rp_res;

    assign rp_sign = op[1] ? sxor : s_big;
    assign rp_exp = op == OP_MUL ? mul_exp : op == OP_DIV ? div_exp : add_exp;
    assign rp_man = op == OP_MUL ? mul_man : op == OP_DIV ? div_man : add_man;

    fpu_round_pack u_round_pack (
        .sign_i (rp_sign),
        .exp_i  (rp_exp),
        .man_i  (rp_man),
        .res_o  (rp_res)
    );

    logic        spc;
    logic [31:0] spc_val;

    always_comb begin
        spc = 1'b1;
        spc_val = QNAN;
        if (a_nan || b_nan) spc_val = QNAN;
        else if (!op[1]) begin
            if (a_inf && b_inf && eff_sub) spc_val = QNAN;
            else if (a_inf) spc_val = {fa.sign, POS_INF[30:0]};
            else if (b_inf) spc_val = {sb_e, POS_INF[30:0]};
            else if (sum == 28'd0) spc_val = {fa.sign & sb_e, 31'd0};
            else spc = 1'b0;
        end else if (op == OP_MUL) begin
            if ((a_inf && b_zero) || (a_zero && b_inf)) spc_val = QNAN;
            else if (a_inf || b_inf) spc_val = {sxor, POS_INF[30:0]};
            else if (a_zero || b_zero) spc_val = {sxor, 31'd0};
            else spc = 1'b0;
        end else begin
            if ((a_zero && b_zero) || (a_inf && b_inf)) spc_val = QNAN;
            else if (b_zero) spc_val = {sxor, POS_INF[30:0]};
            else if (b_inf) spc_val = {sxor, 31'd0};
            else if (a_inf) spc_val = {sxor, POS_INF[30:0]};
            else if (a_zero) spc_val = {sxor, 31'd0};
            else spc = 1'b0;
        end
    end

    logic [31:0] result_d, result_q;

    assign result_d = spc ? spc_val : rp_res;

    always_ff @(posedge clk)
        result_q <= rst ? 32'd0 : result_d;

    assign result = result_q;
endmodule

// File: tb/tb_fpu.sv
// tb_fpu: directed scoreboard bench for fpu; expected results are queued when operands are driven.
module tb_fpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [1:0]  op = 2'd0;
    logic [31:0] result;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    fpu dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check();
        logic [31:0] e;
        string t;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: got %h expected <queued value>", result);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (result === e) else begin
                n_err++;
                $error("FAIL %s: got %h expected %h", t, result, e);
            end
        end
    endtask

    task automatic step(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vop,
                        input logic [31:0] e, input string t);
        a = va;
        b = vb;
        op = vop;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        rst = 1'b1;
        a = 32'h3F800000;
        b = 32'h3F800000;
        op = 2'b00;
        exp_q.push_back(32'h00000000); tag_q.push_back("reset_0");
        @(posedge clk); #1; check();
        exp_q.push_back(32'h00000000); tag_q.push_back("reset_1");
        @(posedge clk); #1; check();
        rst = 1'b0;
        step(32'h3F800000, 32'h3F800000, 2'b00, 32'h40000000, "post_reset_add");
        step(32'h40A00000, 32'h40000000, 2'b01, 32'h40400000, "sub_5_2");
        step(32'h40400000, 32'h40000000, 2'b10, 32'h40C00000, "mul_3_2");
        step(32'h40800000, 32'h40000000, 2'b11, 32'h40000000, "div_4_2");
        step(32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, "add_1_2");
        step(32'h7F800000, 32'hFF800000, 2'b00, 32'h7FC00000, "inf_minus_inf");
        step(32'h7FC00000, 32'h3F800000, 2'b01, 32'h7FC00000, "nan_in");
        step(32'h3F800000, 32'h00000000, 2'b11, 32'h7F800000, "div_by_zero");
        step(32'h80000000, 32'h3F800000, 2'b11, 32'h80000000, "neg_zero_div");
        step(32'h00000001, 32'h3F800000, 2'b10, 32'h00000000, "denorm_mul");
        step(32'h00000002, 32'h7F7FFFFF, 2'b11, 32'h00000000, "denorm_div");
        step(32'h4EFFFFFF, 32'h3F800000, 2'b10, 32'h4EFFFFFF, "mul_exact");
        step(32'h3F800000, 32'h33800000, 2'b00, 32'h3F800000, "add_tie_even");
        step(32'h7F7FFFFF, 32'h40000000, 2'b10, 32'h7F800000, "mul_overflow");
        step(32'h3F800000, 32'h3F800000, 2'b00, 32'h40000000, "b2b_add");
        step(32'h40400000, 32'h40400000, 2'b10, 32'h41100000, "b2b_mul_9");
        step(32'h41100000, 32'h40400000, 2'b11, 32'h40400000, "b2b_div_3");
        step(32'h40000000, 32'h40400000, 2'b01, 32'hBF800000, "b2b_sub_neg");
        step(32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000, "b2b_sub_zero");
        step(32'h80000000, 32'h80000000, 2'b00, 32'h80000000, "b2b_negzero_sum");
        step(32'hC0000000, 32'h40000000, 2'b10, 32'hC0800000, "b2b_mul_neg");
        step(32'h3F800000, 32'h40400000, 2'b11, 32'h3EAAAAAB, "b2b_div_third");
        rst = 1'b1;
        step(32'h40400000, 32'h40000000, 2'b10, 32'h00000000, "reset_priority");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
